bit_packer: RTL and testbench

//   Variable-length bit packer: accepts codes of 0..WIDTH bits per beat and

---
 rtl/bit_packer.sv | 112 +++++++++++
 tb/tb_bit_packer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/bit_packer.sv
// Packs 0..WIDTH-bit codes LSB-first into WIDTH-bit words; a word completed on edge k shows on edge k+1.
// Input stalls (in_ready low) while a full word waits for a busy output slot or a flush is in progress.
module bit_packer #(
  parameter int WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  input  logic [$clog2(WIDTH):0] in_len,
  input  logic                   flush,
  output logic                   flush_done,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_last,
  output logic [$clog2(WIDTH):0] fill_level
);
  localparam int LW = $clog2(WIDTH) + 1;
  localparam logic [LW-1:0] W_L = LW'(WIDTH);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t             state, state_n;
  logic [2*WIDTH-1:0] acc, acc_n;
  logic [LW-1:0]      fill, fill_n;
  logic               armed, armed_n;
  logic               out_valid_n, out_last_n, flush_done_n;
  logic [WIDTH-1:0]   out_data_n;
  logic [LW-1:0]      len;
  logic [WIDTH-1:0]   ones, masked;
  logic               slot_free, accept;

  assign len        = (in_len > W_L) ? W_L : in_len;
  assign ones       = '1;
  assign masked     = in_data & (ones >> (W_L - len));
  assign slot_free  = !out_valid || out_ready;
  assign in_ready   = (state == RUN) && (fill < W_L) && !flush;
  assign accept     = in_valid && in_ready;
  assign fill_level = fill;

  always_comb begin
    state_n      = state;
    acc_n        = acc;
    fill_n       = fill;
    armed_n      = armed;
    out_valid_n  = out_valid;
    out_data_n   = out_data;
    out_last_n   = out_last;
    flush_done_n = 1'b0;

    // A held flush must be seen low once before it can start another flush.
    if (!flush) armed_n = 1'b1;
    if (out_valid && out_ready) out_valid_n = 1'b0;

    case (state)
      RUN: begin
        if (accept) begin
          acc_n  = acc | ({{WIDTH{1'b0}}, masked} << fill);
          fill_n = fill + len;
        end else if (fill >= W_L && slot_free) begin
          out_data_n  = acc[WIDTH-1:0];
          out_valid_n = 1'b1;
          out_last_n  = 1'b0;
          acc_n       = acc >> WIDTH;
          fill_n      = fill - W_L;
        end else if (flush && armed && fill < W_L) begin
          state_n = FLUSH;
          armed_n = 1'b0;
        end
      end
      FLUSH: begin
        if (fill == '0) begin
          flush_done_n = 1'b1;
          state_n      = RUN;
        end else if (slot_free) begin
          out_data_n   = acc[WIDTH-1:0];
          out_valid_n  = 1'b1;
          out_last_n   = 1'b1;
          acc_n        = '0;
          fill_n       = '0;
          flush_done_n = 1'b1;
          state_n      = RUN;
        end
      end
      default: state_n = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      acc        <= '0;
      fill       <= '0;
      armed      <= 1'b1;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
      flush_done <= 1'b0;
    end else begin
      state      <= state_n;
      acc        <= acc_n;
      fill       <= fill_n;
      armed      <= armed_n;
      out_valid  <= out_valid_n;
      out_data   <= out_data_n;
      out_last   <= out_last_n;
      flush_done <= flush_done_n;
    end
  end
endmodule

// File: tb/tb_bit_packer.sv
// Bench for bit_packer: directed cases plus random codes against a bit-queue reference model.
module tb_bit_packer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic [4:0]  in_len = '0;
  logic        flush = 1'b0;
  logic        flush_done;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_last;
  logic [4:0]  fill_level;

  bit          rnd_mode = 1'b0;
  logic        rdy_force = 1'b1;
  logic        rdy_rnd = 1'b1;
  assign out_ready = rnd_mode ? rdy_rnd : rdy_force;

  int          errors = 0;
  int          checks = 0;
  int          fd_cycles = 0;
  int          word_cnt = 0;
  logic [15:0] last_word = '0;
  logic        last_flag = 1'b0;

  // Reference model: a plain queue of bits, LSB of each code first.
  bit          bits[$];
  logic [16:0] exp_q[$];

  bit_packer #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_len(in_len),
    .flush(flush), .flush_done(flush_done),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .fill_level(fill_level)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_push(input logic [15:0] d, input int l);
    int le;
    logic [15:0] w;
    le = (l > 16) ? 16 : l;
    for (int i = 0; i < le; i++) bits.push_back(d[i]);
    while (bits.size() >= 16) begin
      for (int i = 0; i < 16; i++) w[i] = bits.pop_front();
      exp_q.push_back({1'b0, w});
    end
  endfunction

  function automatic void model_flush();
    logic [15:0] w;
    int n;
    w = '0;
    n = bits.size();
    if (n > 0) begin
      for (int i = 0; i < n; i++) w[i] = bits.pop_front();
      exp_q.push_back({1'b1, w});
    end
  endfunction

  always @(negedge clk) rdy_rnd = ($urandom_range(0, 3) != 0);

  // Output monitor: values are stable half a cycle before the edge that consumes them.
  always @(negedge clk) begin
    #1;
    if (!rst) begin
      if (flush_done) fd_cycles++;
      if (out_valid && out_ready) begin
        word_cnt++;
        last_word = out_data;
        last_flag = out_last;
        if (exp_q.size() == 0) check("unexpected_word", 32'(out_valid), 32'd0);
        else check("word", {15'b0, out_last, out_data}, {15'b0, exp_q.pop_front()});
      end
    end
  end

  task automatic send(input logic [15:0] d, input int l);
    int n;
    n = 0;
    in_data  = d;
    in_len   = 5'(l);
    in_valid = 1'b1;
    while (!in_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
    end else begin
      @(negedge clk);
      in_valid = 1'b0;
      model_push(d, l);
    end
  endtask

  task automatic do_flush();
    int fd0, n;
    fd0 = fd_cycles;
    n   = 0;
    model_flush();
    flush = 1'b1;
    while (fd_cycles == fd0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    flush = 1'b0;
    repeat (2) @(negedge clk);
    check("flush_done_cycles", 32'(fd_cycles - fd0), 32'd1);
  endtask

  task automatic drain();
    rnd_mode  = 1'b0;
    rdy_force = 1'b1;
    repeat (6) @(negedge clk);
    check("fill_level", 32'(fill_level), 32'(bits.size()));
    check("pending_words", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int wc0;

    // Reset
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_fill", 32'(fill_level), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_flush_done", 32'(flush_done), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Four nibbles form one word; check one-cycle emit latency
    send(16'hA, 4);
    send(16'hB, 4);
    send(16'hC, 4);
    send(16'hD, 4);
    check("latency_pre", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("latency_post", 32'(out_valid), 32'd1);
    check("dcba_data", 32'(out_data), 32'hDCBA);
    drain();
    check("dcba_last_word", 32'(last_word), 32'hDCBA);

    // Straddling code then flush of the 4-bit residue
    send(16'h0FFF, 12);
    send(16'h005A, 8);
    drain();
    check("afff_word", 32'(last_word), 32'hAFFF);
    check("afff_fill", 32'(fill_level), 32'd4);
    do_flush();
    drain();
    check("flush_word", 32'(last_word), 32'h0005);
    check("flush_last", 32'(last_flag), 32'd1);

    // Backpressure
    rdy_force = 1'b0;
    wc0 = word_cnt;
    send(16'h01, 8);
    send(16'h02, 8);
    send(16'h03, 8);
    send(16'h04, 8);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_out_valid", 32'(out_valid), 32'd1);
    check("bp_out_data", 32'(out_data), 32'h0201);
    check("bp_fill", 32'(fill_level), 32'd16);
    rdy_force = 1'b1;
    drain();
    check("bp_word_cnt", 32'(word_cnt - wc0), 32'd2);
    check("bp_last_word", 32'(last_word), 32'h0403);

    // Masking, zero length, clamping of oversize length
    send(16'hFFFF, 3);
    send(16'h1234, 0);
    check("mask_fill", 32'(fill_level), 32'd3);
    send(16'hABCD, 20);
    drain();
    check("clamp_word", 32'(last_word), 32'h5E6F);
    do_flush();
    drain();
    check("clamp_flush_word", 32'(last_word), 32'h0005);

    // Flush with nothing held
    wc0 = word_cnt;
    do_flush();
    check("empty_flush_words", 32'(word_cnt - wc0), 32'd0);

    // Reset mid-word
    send(16'h01FF, 9);
    check("pre_rst_fill", 32'(fill_level), 32'd9);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bits.delete();
    exp_q.delete();
    check("post_rst_fill", 32'(fill_level), 32'd0);
    check("post_rst_valid", 32'(out_valid), 32'd0);
    send(16'h1357, 16);
    drain();
    check("post_rst_word", 32'(last_word), 32'h1357);

    // Random codes, random backpressure, occasional flushes
    rnd_mode = 1'b1;
    for (int i = 0; i < 400; i++) begin
      send(16'($urandom), int'($urandom_range(0, 20)));
      if ($urandom_range(0, 29) == 0) do_flush();
    end
    do_flush();
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
